// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: command front-end for an 8x8 synchronous RAM.
//   Accepts single/burst read or write commands (valid/ready), drives the RAM
//   write_en/addr/data_in pins, absorbs the RAM's 1-cycle registered read
//   latency and returns read beats on a back-pressurable response stream.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid/ready/write/addr/len  command channel (beats = cmd_len+1)
//   wr_valid/ready/data          write-data beats
//   rsp_valid/ready/data/last    read response stream
//   ram_write_en/addr/data_in    to RAM; ram_data_out from RAM
// Optional: define RAM_BURST_WRAP_ERR_EN to add output cmd_err, a one-cycle
//   pulse after accepting a command whose burst wraps past the top address.
module ram_burst_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_BURST_WRAP_ERR_EN
  ,
  output logic              cmd_err
`endif
);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, RD_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_last_q, rsp_last_d;
  logic                accept;

  // Gated by reset_n so the command channel reads 0 while reset is held.
  assign cmd_ready    = (state_q == IDLE) && reset_n;
  assign accept       = cmd_valid && cmd_ready;
  assign wr_ready     = (state_q == WR);
  assign ram_write_en = (state_q == WR) && wr_valid;
  assign ram_addr     = cur_addr_q;
  assign ram_data_in  = (state_q == WR) ? wr_data : '0;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_last     = rsp_last_q;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_last_d   = rsp_last_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
          state_d      = cmd_write ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (beats_left_q == '0) state_d = IDLE;
          else beats_left_d = beats_left_q - LEN_W'(1);
        end
      end
      // Address presented this cycle; RAM registers it on the next edge.
      RD_ADDR: state_d = RD_CAP;
      // RAM output now valid for cur_addr; capture into the response register.
      RD_CAP: begin
        rsp_data_d  = ram_data_out;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (beats_left_q == '0);
        state_d     = RD_RESP;
      end
      RD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_W'(1);
            beats_left_d = beats_left_q - LEN_W'(1);
            state_d      = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

`ifdef RAM_BURST_WRAP_ERR_EN
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  logic [SUM_W-1:0] end_addr;
  logic             cmd_err_q, cmd_err_d;

  assign end_addr  = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign cmd_err_d = accept && (end_addr > SUM_W'((2**ADDR_W) - 1));
  assign cmd_err   = cmd_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cmd_err_q <= 1'b0;
    else          cmd_err_q <= cmd_err_d;
  end
`else
  // Wrap-around is silent in this build.
`endif

endmodule
